// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//
// Hardwired control sequencer for a small load/store CPU. Every instruction
// runs a three-step fetch (T0..T2) followed by up to five execute steps
// (T3..T7). The opcode comes from IR[31:27] and is only looked at from T3
// on. All control outputs are decoded combinationally from the registered
// state, plus OpCode and CON. Step exposes the state code directly, which
// lets checkers follow the sequencer without probing internals.
//
// Ports
//   Clock   in   1   system clock; state changes on the rising edge
//   Clear   in   1   synchronous active-high reset; forces RST from any state
//   OpCode  in   5   IR[31:27]
//   CON     in   1   branch condition flip-flop output
//   Stop    in   1   halt request, sampled in an instruction's last step
//   Run     out  1   1 = sequencing, 0 = halted
//   BusSel  out 10   one-hot bus source select
//                    [0]PCout [1]Zlowout [2]Zhighout [3]MDRout [4]HIout
//                    [5]LOout [6]Cout [7]Rout [8]BAout [9]OutPortOut
//   LdEn    out 11   load enables
//                    [0]PCin [1]IRin [2]MARin [3]MDRin [4]Yin [5]Zin
//                    [6]HIin [7]LOin [8]Rin [9]CONin [10]OutPortIn
//   RegSel  out  3   {Grc,Grb,Gra}
//   MemCtl  out  2   {Write,Read}
//   IncPC   out  1   ALU increments the PC value on the bus
//   ALUop   out 13   one-hot ALU function
//                    [0]ADD [1]SUB [2]AND [3]OR [4]ROR [5]ROL [6]SHR
//                    [7]SHRA [8]SHL [9]MUL [10]DIV [11]NEG [12]NOT
//   Step    out  4   state code: T0..T7 = 0..7, RST = 8, HALT = 9
//
// Build option
//   CONTROL_UNIT_MULDIV_EN  when defined, mul/div run a four-step execute
//                           sequence writing LO then HI. When undefined,
//                           mul/div decode as nop and ALUop[9]/[10] stay 0.
//
// Handshake: none. There is no valid/ready pair; Stop and Clear are plain
// levels sampled on the rising edge of Clock.
// ---------------------------------------------------------------------------
module control_unit (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [4:0]  OpCode,
  input  logic        CON,
  input  logic        Stop,
  output logic        Run,
  output logic [9:0]  BusSel,
  output logic [10:0] LdEn,
  output logic [2:0]  RegSel,
  output logic [1:0]  MemCtl,
  output logic        IncPC,
  output logic [12:0] ALUop,
  output logic [3:0]  Step
);

  // State codes are visible on Step, so the encoding is fixed.
  typedef enum logic [3:0] {
    S_T0   = 4'd0,
    S_T1   = 4'd1,
    S_T2   = 4'd2,
    S_T3   = 4'd3,
    S_T4   = 4'd4,
    S_T5   = 4'd5,
    S_T6   = 4'd6,
    S_T7   = 4'd7,
    S_RST  = 4'd8,
    S_HALT = 4'd9
  } state_e;

  // Opcodes
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // BusSel bit positions
  localparam int B_PCOUT  = 0;
  localparam int B_ZLOOUT = 1;
  localparam int B_ZHIOUT = 2;
  localparam int B_MDROUT = 3;
  localparam int B_HIOUT  = 4;
  localparam int B_LOOUT  = 5;
  localparam int B_COUT   = 6;
  localparam int B_ROUT   = 7;
  localparam int B_BAOUT  = 8;
  localparam int B_OPOUT  = 9;

  // LdEn bit positions
  localparam int L_PCIN  = 0;
  localparam int L_IRIN  = 1;
  localparam int L_MARIN = 2;
  localparam int L_MDRIN = 3;
  localparam int L_YIN   = 4;
  localparam int L_ZIN   = 5;
  localparam int L_HIIN  = 6;
  localparam int L_LOIN  = 7;
  localparam int L_RIN   = 8;
  localparam int L_CONIN = 9;
  localparam int L_OPIN  = 10;

  // RegSel / MemCtl / ALUop bit positions
  localparam int G_A      = 0;
  localparam int G_B      = 1;
  localparam int G_C      = 2;
  localparam int M_READ   = 0;
  localparam int M_WRITE  = 1;
  localparam int A_ADD    = 0;
  localparam int A_AND    = 2;
  localparam int A_OR     = 3;
  localparam int A_NEG    = 11;
  localparam int A_NOT    = 12;
`ifdef CONTROL_UNIT_MULDIV_EN
  localparam int A_MUL    = 9;
  localparam int A_DIV    = 10;
`endif

  state_e state_q, state_d;
  state_e last_state;

  logic        run;
  logic [9:0]  bus_sel;
  logic [10:0] ld_en;
  logic [2:0]  reg_sel;
  logic [1:0]  mem_ctl;
  logic        inc_pc;
  logic [12:0] alu_op;

  // -------------------------------------------------------------------------
  // Final execute step of each instruction; the step after it is T0 (or HALT
  // when Stop is high).
  // -------------------------------------------------------------------------
  always_comb begin : last_step_decode
    last_state = S_T3;
    case (OpCode)
      OP_LD:                             last_state = S_T7;
      OP_LDI:                            last_state = S_T5;
      OP_ST:                             last_state = S_T6;
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ROR, OP_ROL, OP_SHR, OP_SHRA,
      OP_SHL:                            last_state = S_T5;
      OP_ADDI, OP_ANDI, OP_ORI:          last_state = S_T5;
`ifdef CONTROL_UNIT_MULDIV_EN
      OP_MUL, OP_DIV:                    last_state = S_T6;
`else
      OP_MUL, OP_DIV:                    last_state = S_T3;
`endif
      OP_NEG, OP_NOT:                    last_state = S_T4;
      OP_BR:                             last_state = S_T6;
      OP_JAL:                            last_state = S_T4;
      default:                           last_state = S_T3;
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state logic. Clear is applied in the register itself.
  // -------------------------------------------------------------------------
  always_comb begin : next_state_decode
    state_d = state_q;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (state_q == S_T3 && OpCode == OP_HALT) begin
          // halt ignores Stop: it always parks the sequencer
          state_d = S_HALT;
        end else if (state_q == last_state) begin
          state_d = Stop ? S_HALT : S_T0;
        end else begin
          state_d = state_e'(state_q + 4'd1);
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;  // unused codes recover through RST
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Control decode. Everything defaults to 0, so RST, HALT, nop, halt and
  // unused opcodes need no explicit entries.
  // -------------------------------------------------------------------------
  always_comb begin : control_decode
    run     = (state_q != S_HALT);
    bus_sel = '0;
    ld_en   = '0;
    reg_sel = '0;
    mem_ctl = '0;
    inc_pc  = 1'b0;
    alu_op  = '0;

    case (state_q)
      S_T0: begin
        bus_sel[B_PCOUT] = 1'b1;
        ld_en[L_MARIN]   = 1'b1;
        ld_en[L_ZIN]     = 1'b1;
        inc_pc           = 1'b1;
      end
      S_T1: begin
        bus_sel[B_ZLOOUT] = 1'b1;
        ld_en[L_PCIN]     = 1'b1;
        ld_en[L_MDRIN]    = 1'b1;
        mem_ctl[M_READ]   = 1'b1;
      end
      S_T2: begin
        bus_sel[B_MDROUT] = 1'b1;
        ld_en[L_IRIN]     = 1'b1;
      end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        case (OpCode)
          OP_LD, OP_LDI, OP_ST: begin
            // Shared effective-address computation: Z <= BA(Rb) + C
            case (state_q)
              S_T3: begin
                bus_sel[B_BAOUT] = 1'b1;
                reg_sel[G_B]     = 1'b1;
                ld_en[L_YIN]     = 1'b1;
              end
              S_T4: begin
                bus_sel[B_COUT] = 1'b1;
                alu_op[A_ADD]   = 1'b1;
                ld_en[L_ZIN]    = 1'b1;
              end
              S_T5: begin
                bus_sel[B_ZLOOUT] = 1'b1;
                if (OpCode == OP_LDI) begin
                  reg_sel[G_A] = 1'b1;
                  ld_en[L_RIN] = 1'b1;
                end else begin
                  ld_en[L_MARIN] = 1'b1;
                end
              end
              S_T6: begin
                if (OpCode == OP_LD) begin
                  mem_ctl[M_READ] = 1'b1;
                  ld_en[L_MDRIN]  = 1'b1;
                end else if (OpCode == OP_ST) begin
                  bus_sel[B_ROUT]  = 1'b1;
                  reg_sel[G_A]     = 1'b1;
                  mem_ctl[M_WRITE] = 1'b1;
                end
              end
              S_T7: begin
                if (OpCode == OP_LD) begin
                  bus_sel[B_MDROUT] = 1'b1;
                  reg_sel[G_A]      = 1'b1;
                  ld_en[L_RIN]      = 1'b1;
                end
              end
              default: ;
            endcase
          end

          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA,
          OP_SHL, OP_ADDI, OP_ANDI, OP_ORI: begin
            case (state_q)
              S_T3: begin
                bus_sel[B_ROUT] = 1'b1;
                reg_sel[G_B]    = 1'b1;
                ld_en[L_YIN]    = 1'b1;
              end
              S_T4: begin
                ld_en[L_ZIN] = 1'b1;
                case (OpCode)
                  OP_ADDI: begin bus_sel[B_COUT] = 1'b1; alu_op[A_ADD] = 1'b1; end
                  OP_ANDI: begin bus_sel[B_COUT] = 1'b1; alu_op[A_AND] = 1'b1; end
                  OP_ORI:  begin bus_sel[B_COUT] = 1'b1; alu_op[A_OR]  = 1'b1; end
                  default: begin
                    // add..shl are contiguous opcodes in ALUop bit order
                    bus_sel[B_ROUT] = 1'b1;
                    reg_sel[G_C]    = 1'b1;
                    alu_op          = 13'd1 << (OpCode - OP_ADD);
                  end
                endcase
              end
              S_T5: begin
                bus_sel[B_ZLOOUT] = 1'b1;
                reg_sel[G_A]      = 1'b1;
                ld_en[L_RIN]      = 1'b1;
              end
              default: ;
            endcase
          end

`ifdef CONTROL_UNIT_MULDIV_EN
          OP_MUL, OP_DIV: begin
            // 64-bit result: low half to LO, then high half to HI
            case (state_q)
              S_T3: begin
                bus_sel[B_ROUT] = 1'b1;
                reg_sel[G_A]    = 1'b1;
                ld_en[L_YIN]    = 1'b1;
              end
              S_T4: begin
                bus_sel[B_ROUT] = 1'b1;
                reg_sel[G_B]    = 1'b1;
                ld_en[L_ZIN]    = 1'b1;
                if (OpCode == OP_MUL) alu_op[A_MUL] = 1'b1;
                else                  alu_op[A_DIV] = 1'b1;
              end
              S_T5: begin
                bus_sel[B_ZLOOUT] = 1'b1;
                ld_en[L_LOIN]     = 1'b1;
              end
              S_T6: begin
                bus_sel[B_ZHIOUT] = 1'b1;
                ld_en[L_HIIN]     = 1'b1;
              end
              default: ;
            endcase
          end
`else
          OP_MUL, OP_DIV: ;  // treated as nop: one idle T3 step
`endif

          OP_NEG, OP_NOT: begin
            case (state_q)
              S_T3: begin
                bus_sel[B_ROUT] = 1'b1;
                reg_sel[G_B]    = 1'b1;
                ld_en[L_ZIN]    = 1'b1;
                if (OpCode == OP_NEG) alu_op[A_NEG] = 1'b1;
                else                  alu_op[A_NOT] = 1'b1;
              end
              S_T4: begin
                bus_sel[B_ZLOOUT] = 1'b1;
                reg_sel[G_A]      = 1'b1;
                ld_en[L_RIN]      = 1'b1;
              end
              default: ;
            endcase
          end

          OP_BR: begin
            case (state_q)
              S_T3: begin
                bus_sel[B_ROUT] = 1'b1;
                reg_sel[G_A]    = 1'b1;
                ld_en[L_CONIN]  = 1'b1;
              end
              S_T4: begin
                bus_sel[B_PCOUT] = 1'b1;
                ld_en[L_YIN]     = 1'b1;
              end
              S_T5: begin
                bus_sel[B_COUT] = 1'b1;
                alu_op[A_ADD]   = 1'b1;
                ld_en[L_ZIN]    = 1'b1;
              end
              S_T6: begin
                // target is always driven; PC only takes it when taken
                bus_sel[B_ZLOOUT] = 1'b1;
                ld_en[L_PCIN]     = CON;
              end
              default: ;
            endcase
          end

          OP_JR: begin
            if (state_q == S_T3) begin
              bus_sel[B_ROUT] = 1'b1;
              reg_sel[G_A]    = 1'b1;
              ld_en[L_PCIN]   = 1'b1;
            end
          end

          OP_JAL: begin
            case (state_q)
              S_T3: begin
                bus_sel[B_PCOUT] = 1'b1;
                reg_sel[G_B]     = 1'b1;
                ld_en[L_RIN]     = 1'b1;
              end
              S_T4: begin
                bus_sel[B_ROUT] = 1'b1;
                reg_sel[G_A]    = 1'b1;
                ld_en[L_PCIN]   = 1'b1;
              end
              default: ;
            endcase
          end

          OP_IN, OP_MFHI, OP_MFLO: begin
            if (state_q == S_T3) begin
              reg_sel[G_A] = 1'b1;
              ld_en[L_RIN] = 1'b1;
              case (OpCode)
                OP_IN:   bus_sel[B_OPOUT] = 1'b1;
                OP_MFHI: bus_sel[B_HIOUT] = 1'b1;
                default: bus_sel[B_LOOUT] = 1'b1;
              endcase
            end
          end

          OP_OUT: begin
            if (state_q == S_T3) begin
              bus_sel[B_ROUT] = 1'b1;
              reg_sel[G_A]    = 1'b1;
              ld_en[L_OPIN]   = 1'b1;
            end
          end

          default: ;  // nop, halt and unused opcodes drive nothing
        endcase
      end
      default: ;  // RST and HALT drive nothing
    endcase
  end

  assign Run    = run;
  assign BusSel = bus_sel;
  assign LdEn   = ld_en;
  assign RegSel = reg_sel;
  assign MemCtl = mem_ctl;
  assign IncPC  = inc_pc;
  assign ALUop  = alu_op;
  assign Step   = state_q;

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
//
// Self-checking bench for control_unit. The reference model expands each
// opcode into its full microprogram (a queue of control words, one per
// step, fetch included). The bench walks the DUT through the instruction,
// comparing Step, Run and the control word on every cycle, then checks
// where the sequencer went next (T0, HALT, or RST on a mid-instruction
// Clear). Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_control_unit;

  logic        Clock;
  logic        Clear;
  logic [4:0]  OpCode;
  logic        CON;
  logic        Stop;
  logic        Run;
  logic [9:0]  BusSel;
  logic [10:0] LdEn;
  logic [2:0]  RegSel;
  logic [1:0]  MemCtl;
  logic        IncPC;
  logic [12:0] ALUop;
  logic [3:0]  Step;

  control_unit dut (
    .Clock  (Clock),
    .Clear  (Clear),
    .OpCode (OpCode),
    .CON    (CON),
    .Stop   (Stop),
    .Run    (Run),
    .BusSel (BusSel),
    .LdEn   (LdEn),
    .RegSel (RegSel),
    .MemCtl (MemCtl),
    .IncPC  (IncPC),
    .ALUop  (ALUop),
    .Step   (Step)
  );

  // ---------------- clock / reset block ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- control word model ----------------
  typedef struct packed {
    logic [9:0]  bus;
    logic [10:0] ld;
    logic [2:0]  rs;
    logic [1:0]  mem;
    logic        inc;
    logic [12:0] alu;
  } cw_t;

  localparam logic [9:0] B_PC  = 10'h001, B_ZLO = 10'h002, B_ZHI = 10'h004,
                         B_MDR = 10'h008, B_HI  = 10'h010, B_LO  = 10'h020,
                         B_C   = 10'h040, B_R   = 10'h080, B_BA  = 10'h100,
                         B_OP  = 10'h200;
  localparam logic [10:0] L_PC  = 11'h001, L_IR  = 11'h002, L_MAR = 11'h004,
                          L_MDR = 11'h008, L_Y   = 11'h010, L_Z   = 11'h020,
                          L_HI  = 11'h040, L_LO  = 11'h080, L_R   = 11'h100,
                          L_CON = 11'h200, L_OP  = 11'h400;
  localparam logic [2:0] G_A = 3'b001, G_B = 3'b010, G_C = 3'b100;
  localparam logic [1:0] M_RD = 2'b01, M_WR = 2'b10;
  localparam logic [12:0] A_ADD = 13'h0001, A_AND = 13'h0004, A_OR = 13'h0008,
                          A_MUL = 13'h0200, A_DIV = 13'h0400,
                          A_NEG = 13'h0800, A_NOT = 13'h1000;
  localparam cw_t CW_ZERO = '0;

  // ALU function for the nine three-register ops, in opcode order
  logic [12:0] alu3_tab [9];
  initial begin
    alu3_tab[0] = 13'h0001; // add
    alu3_tab[1] = 13'h0002; // sub
    alu3_tab[2] = 13'h0004; // and
    alu3_tab[3] = 13'h0008; // or
    alu3_tab[4] = 13'h0010; // ror
    alu3_tab[5] = 13'h0020; // rol
    alu3_tab[6] = 13'h0040; // shr
    alu3_tab[7] = 13'h0080; // shra
    alu3_tab[8] = 13'h0100; // shl
  end

  cw_t prog_q[$];   // expected control words for the current instruction

  function automatic cw_t mk(logic [9:0] b, logic [10:0] l, logic [2:0] r,
                             logic [1:0] m, logic i, logic [12:0] a);
    cw_t c;
    c.bus = b; c.ld = l; c.rs = r; c.mem = m; c.inc = i; c.alu = a;
    return c;
  endfunction

  function automatic void build_prog(input logic [4:0] op, input logic con);
    int o;
    o = int'(op);
    prog_q.delete();
    prog_q.push_back(mk(B_PC,  L_MAR | L_Z,   3'b0, 2'b0, 1'b1, 13'h0));
    prog_q.push_back(mk(B_ZLO, L_PC | L_MDR,  3'b0, M_RD, 1'b0, 13'h0));
    prog_q.push_back(mk(B_MDR, L_IR,          3'b0, 2'b0, 1'b0, 13'h0));
    if (o <= 2) begin
      prog_q.push_back(mk(B_BA, L_Y, G_B, 2'b0, 1'b0, 13'h0));
      prog_q.push_back(mk(B_C,  L_Z, 3'b0, 2'b0, 1'b0, A_ADD));
      if (o == 1) begin
        prog_q.push_back(mk(B_ZLO, L_R, G_A, 2'b0, 1'b0, 13'h0));
      end else begin
        prog_q.push_back(mk(B_ZLO, L_MAR, 3'b0, 2'b0, 1'b0, 13'h0));
        if (o == 0) begin
          prog_q.push_back(mk(10'h0, L_MDR, 3'b0, M_RD, 1'b0, 13'h0));
          prog_q.push_back(mk(B_MDR, L_R, G_A, 2'b0, 1'b0, 13'h0));
        end else begin
          prog_q.push_back(mk(B_R, 11'h0, G_A, M_WR, 1'b0, 13'h0));
        end
      end
    end else if (o >= 3 && o <= 11) begin
      prog_q.push_back(mk(B_R,   L_Y, G_B, 2'b0, 1'b0, 13'h0));
      prog_q.push_back(mk(B_R,   L_Z, G_C, 2'b0, 1'b0, alu3_tab[o-3]));
      prog_q.push_back(mk(B_ZLO, L_R, G_A, 2'b0, 1'b0, 13'h0));
    end else if (o >= 12 && o <= 14) begin
      prog_q.push_back(mk(B_R,   L_Y, G_B,  2'b0, 1'b0, 13'h0));
      prog_q.push_back(mk(B_C,   L_Z, 3'b0, 2'b0, 1'b0,
                          (o == 12) ? A_ADD : (o == 13) ? A_AND : A_OR));
      prog_q.push_back(mk(B_ZLO, L_R, G_A,  2'b0, 1'b0, 13'h0));
    end else if (o == 15 || o == 16) begin
`ifdef CONTROL_UNIT_MULDIV_EN
      prog_q.push_back(mk(B_R,   L_Y,  G_A,  2'b0, 1'b0, 13'h0));
      prog_q.push_back(mk(B_R,   L_Z,  G_B,  2'b0, 1'b0, (o == 15) ? A_MUL : A_DIV));
      prog_q.push_back(mk(B_ZLO, L_LO, 3'b0, 2'b0, 1'b0, 13'h0));
      prog_q.push_back(mk(B_ZHI, L_HI, 3'b0, 2'b0, 1'b0, 13'h0));
`else
      prog_q.push_back(CW_ZERO);
`endif
    end else if (o == 17 || o == 18) begin
      prog_q.push_back(mk(B_R,   L_Z, G_B, 2'b0, 1'b0, (o == 17) ? A_NEG : A_NOT));
      prog_q.push_back(mk(B_ZLO, L_R, G_A, 2'b0, 1'b0, 13'h0));
    end else if (o == 19) begin
      prog_q.push_back(mk(B_R,   L_CON, G_A,  2'b0, 1'b0, 13'h0));
      prog_q.push_back(mk(B_PC,  L_Y,   3'b0, 2'b0, 1'b0, 13'h0));
      prog_q.push_back(mk(B_C,   L_Z,   3'b0, 2'b0, 1'b0, A_ADD));
      prog_q.push_back(mk(B_ZLO, con ? L_PC : 11'h0, 3'b0, 2'b0, 1'b0, 13'h0));
    end else if (o == 20) begin
      prog_q.push_back(mk(B_R, L_PC, G_A, 2'b0, 1'b0, 13'h0));
    end else if (o == 21) begin
      prog_q.push_back(mk(B_PC, L_R,  G_B, 2'b0, 1'b0, 13'h0));
      prog_q.push_back(mk(B_R,  L_PC, G_A, 2'b0, 1'b0, 13'h0));
    end else if (o == 22) begin
      prog_q.push_back(mk(B_OP, L_R, G_A, 2'b0, 1'b0, 13'h0));
    end else if (o == 23) begin
      prog_q.push_back(mk(B_R, L_OP, G_A, 2'b0, 1'b0, 13'h0));
    end else if (o == 24) begin
      prog_q.push_back(mk(B_HI, L_R, G_A, 2'b0, 1'b0, 13'h0));
    end else if (o == 25) begin
      prog_q.push_back(mk(B_LO, L_R, G_A, 2'b0, 1'b0, 13'h0));
    end else begin
      prog_q.push_back(CW_ZERO);   // nop, halt, unused
    end
  endfunction

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_err = 0;

  function automatic cw_t dut_cw();
    return cw_t'({BusSel, LdEn, RegSel, MemCtl, IncPC, ALUop});
  endfunction

  // ---------------- driver tasks ----------------
  // Starts at a falling edge with the DUT in T0. ended: 0 = back in T0,
  // 1 = HALT, 2 = Clear hit at step abort_at and the DUT recovered to T0.
  task automatic run_instr(input logic [4:0] op, input logic con,
                           input logic stop_last, input int abort_at,
                           output int ended);
    int len;
    bit aborted;
    logic [3:0] exp_step;
    build_prog(op, con);
    len = prog_q.size();
    aborted = 1'b0;
    for (int k = 0; k < len; k++) begin
      OpCode = op;
      CON    = con;
      Stop   = (k == len - 1) ? stop_last : 1'($urandom_range(0, 1));
      if (k == abort_at) Clear = 1'b1;
      #1;
      n_cmp++;
      if (Step !== 4'(k)) begin
        n_err++;
        $display("FAIL step_code op=%0d k=%0d: got %0d want %0d", op, k, Step, k);
      end
      n_cmp++;
      if (dut_cw() !== prog_q[k]) begin
        n_err++;
        $display("FAIL controls op=%0d con=%0b k=%0d: got %h want %h",
                 op, con, k, dut_cw(), prog_q[k]);
      end
      n_cmp++;
      if (Run !== 1'b1) begin
        n_err++;
        $display("FAIL run op=%0d k=%0d: got %b want 1", op, k, Run);
      end
      @(negedge Clock);
      if (k == abort_at) begin
        aborted = 1'b1;
        break;
      end
    end
    #1;
    if (aborted) begin
      n_cmp++;
      if (Step !== 4'd8 || dut_cw() !== CW_ZERO || Run !== 1'b1) begin
        n_err++;
        $display("FAIL clear_mid op=%0d: got step=%0d cw=%h run=%b want step=8 cw=0 run=1",
                 op, Step, dut_cw(), Run);
      end
      Clear = 1'b0;
      @(negedge Clock);
      #1;
      n_cmp++;
      if (Step !== 4'd0) begin
        n_err++;
        $display("FAIL clear_release op=%0d: got step %0d want 0", op, Step);
      end
      ended = 2;
    end else begin
      exp_step = (op == 5'b11011 || stop_last) ? 4'd9 : 4'd0;
      n_cmp++;
      if (Step !== exp_step) begin
        n_err++;
        $display("FAIL next_step op=%0d stop=%0b: got %0d want %0d",
                 op, stop_last, Step, exp_step);
      end
      ended = (exp_step == 4'd9) ? 1 : 0;
    end
  endtask

  // Hold in HALT with random inputs; Run must stay 0 and controls idle.
  task automatic hold_halt(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      OpCode = 5'($urandom_range(0, 31));
      Stop   = 1'($urandom_range(0, 1));
      CON    = 1'($urandom_range(0, 1));
      @(negedge Clock);
      #1;
      n_cmp++;
      if (Run !== 1'b0 || Step !== 4'd9 || dut_cw() !== CW_ZERO) begin
        n_err++;
        $display("FAIL halt_hold cyc=%0d: got run=%b step=%0d cw=%h want run=0 step=9 cw=0",
                 i, Run, Step, dut_cw());
      end
    end
  endtask

  // One Clear cycle, then release; ends in T0.
  task automatic do_reset();
    Clear = 1'b1;
    @(negedge Clock);
    #1;
    n_cmp++;
    if (Run !== 1'b1 || Step !== 4'd8 || dut_cw() !== CW_ZERO) begin
      n_err++;
      $display("FAIL reset_state: got run=%b step=%0d cw=%h want run=1 step=8 cw=0",
               Run, Step, dut_cw());
    end
    Clear = 1'b0;
    @(negedge Clock);
    #1;
    n_cmp++;
    if (Step !== 4'd0) begin
      n_err++;
      $display("FAIL reset_release: got step %0d want 0", Step);
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    Clear = 1'b1; OpCode = 5'd0; CON = 1'b0; Stop = 1'b0;
    repeat (2) @(negedge Clock);
    #1;
    n_cmp++;
    if (Run !== 1'b1 || Step !== 4'd8 || dut_cw() !== CW_ZERO) begin
      n_err++;
      $display("FAIL rst_state: got run=%b step=%0d cw=%h want run=1 step=8 cw=0",
               Run, Step, dut_cw());
    end
    Clear = 1'b0;
    @(negedge Clock);
    #1;
    n_cmp++;
    if (Step !== 4'd0 || BusSel !== 10'h001 || LdEn !== 11'h024 || IncPC !== 1'b1) begin
      n_err++;
      $display("FAIL t0_fetch: got step=%0d bus=%h ld=%h inc=%b want 0 001 024 1",
               Step, BusSel, LdEn, IncPC);
    end
  endtask

  task automatic test_ld();
    int e;
    run_instr(5'b00000, 1'($urandom_range(0, 1)), 1'b0, -1, e);
  endtask

  task automatic test_br();
    int e;
    run_instr(5'b10011, 1'b0, 1'b0, -1, e);
    run_instr(5'b10011, 1'b1, 1'b0, -1, e);
  endtask

  task automatic test_muldiv();
    int e;
    run_instr(5'b01111, 1'b0, 1'b0, -1, e);
    run_instr(5'b10000, 1'b1, 1'b0, -1, e);
  endtask

  task automatic test_halt();
    int e;
    run_instr(5'b11011, 1'b0, 1'b0, -1, e);
    if (e == 1) hold_halt(10);
    do_reset();
  endtask

  task automatic test_clear_mid();
    int e;
    run_instr(5'b00011, 1'b0, 1'b0, 4, e);   // Clear during T4 of add
  endtask

  task automatic test_stop();
    int e;
    run_instr(5'b00110, 1'b0, 1'b1, -1, e);  // or with Stop on its last step
    if (e == 1) hold_halt(3);
    do_reset();
  endtask

  task automatic test_sweep();
    int e;
    for (int op = 0; op < 32; op++) begin
      run_instr(5'(op), 1'($urandom_range(0, 1)), 1'b0, -1, e);
      if (e == 1) begin
        hold_halt(2);
        do_reset();
      end
    end
  endtask

  task automatic test_back_to_back();
    int e;
    int ab;
    logic [4:0] op;
    for (int n = 0; n < 80; n++) begin
      op = 5'($urandom_range(0, 31));
      build_prog(op, 1'b0);
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, prog_q.size() - 1)) : -1;
      run_instr(op, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), ab, e);
      if (e == 1) begin
        hold_halt(int'($urandom_range(1, 4)));
        do_reset();
      end
    end
  endtask

  // ---------------- main sequence + final report ----------------
  initial begin
    Clear = 1'b1; OpCode = 5'd0; CON = 1'b0; Stop = 1'b0;
    test_reset();
    test_ld();
    test_br();
    test_muldiv();
    test_clear_mid();
    test_halt();
    test_stop();
    test_sweep();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog: the sequence is a few thousand cycles at most.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
- REQ-001 Clock  input  1  single system clock; all state changes on rising edge.
- REQ-002 Clear  input  1  reset, synchronous, active-high.
- REQ-003 OpCode  input  5  IR[31:27] from datapath IR; valid from T3 onward.
- REQ-004 CON  input  1  branch condition flip-flop output (BranchOut).
- REQ-005 Stop  input  1  halt request, level-sensitive.
- REQ-006 Run  output  1  1 = sequencing, 0 = halted.
- REQ-007 BusSel  output  10  one-hot bus source: [0]PCout [1]Zlowout [2]Zhighout [3]MDRout [4]HIout [5]LOout [6]Cout [7]Rout [8]BAout [9]OutPortOut.
- REQ-008 LdEn  output  11  load enables: [0]PCin [1]IRin [2]MARin [3]MDRin [4]Yin [5]Zin [6]HIin [7]LOin [8]Rin [9]CONin [10]OutPortIn.
- REQ-009 RegSel  output  3  {Grc,Grb,Gra}.
- REQ-010 MemCtl  output  2  {Write,Read}.
- REQ-011 IncPC  output  1  ALU increments PC value on bus.
- REQ-012 ALUop  output  13  one-hot: [0]ADD [1]SUB [2]AND [3]OR [4]ROR [5]ROL [6]SHR [7]SHRA [8]SHL [9]MUL [10]DIV [11]NEG [12]NOT.
- REQ-013 Step  output  4  current state code: T0..T7 = 0..7, RST = 8, HALT = 9.

Function
- REQ-014 States: RST, T0..T7, HALT; one state per cycle; all outputs decoded combinationally from registered state and OpCode/CON; BusSel at most one bit high.
- REQ-015 Fetch: T0 PCout MARin IncPC Zin; T1 Zlowout PCin Read MDRin; T2 MDRout IRin.
- REQ-016 Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, addi 01100, andi 01101, ori 01110, mul 01111, div 10000, neg 10001, not 10010, br 10011, jr 10100, jal 10101, in 10110, out 10111, mfhi 11000, mflo 11001, nop 11010, halt 11011; others = nop.
- REQ-017 ld: T3 Grb BAout Yin; T4 Cout ADD Zin; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
- REQ-018 ldi: T3-T4 as ld; T5 Zlowout Gra Rin. st: T3-T5 as ld; T6 Gra Rout Write.
- REQ-019 Three-register ALU ops: T3 Grb Rout Yin; T4 Grc Rout ALUop Zin; T5 Zlowout Gra Rin.
- REQ-020 addi/andi/ori: T3 Grb Rout Yin; T4 Cout ADD/AND/OR Zin; T5 Zlowout Gra Rin.
- REQ-021 neg/not: T3 Grb Rout ALUop Zin; T4 Zlowout Gra Rin.
- REQ-022 br: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout ADD Zin; T6 Zlowout, PCin only when CON=1 (Zlowout asserted regardless).
- REQ-023 jr: T3 Gra Rout PCin. jal: T3 PCout Grb Rin; T4 Gra Rout PCin.
- REQ-024 in: T3 OutPortOut Gra Rin. out: T3 Gra Rout OutPortIn. mfhi/mflo: T3 HIout/LOout Gra Rin.
- REQ-025 nop: T3 all controls 0. halt: T3 all controls 0, next HALT.
- REQ-026 After each instruction's last step: next T0, or HALT if Stop=1 in that cycle.
- REQ-027 HALT: Run=0, all controls 0; exits only via Clear.

Reset
- REQ-028 Clear=1 at rising edge: next state RST regardless of current state, including mid-instruction; partial instruction abandoned.
- REQ-029 RST: Run=1, all control outputs 0, Step=8; next T0 when Clear=0.

Configuration
- REQ-030 CONTROL_UNIT_MULDIV_EN defined: mul/div sequence T3 Gra Rout Yin; T4 Grb Rout MUL/DIV Zin; T5 Zlowout LOin; T6 Zhighout HIin.
- REQ-031 CONTROL_UNIT_MULDIV_EN undefined: opcodes 01111/10000 decode as nop; ALUop[9]/[10] tied 0.

Verification
- REQ-032 Clear 2 cycles, release -> RST then T0; T0 shows BusSel=0x001, LdEn bits MARin+Zin, IncPC=1.
- REQ-033 OpCode=00000 -> T7 asserts BusSel[3], LdEn[8], Gra; next cycle Step=0.
- REQ-034 br with CON=0 -> T6 BusSel[1]=1, LdEn[0]=0; repeat with CON=1 -> LdEn[0]=1.
- REQ-035 OpCode=11011 -> Step 3 then 9, Run=0 held 10 cycles; Clear -> Run=1, Step=8.
- REQ-036 Clear asserted during T4 of add -> Step=8 next cycle, all controls 0.
- REQ-037 mul with macro: T5 LdEn[7], T6 LdEn[6]+BusSel[2]; without macro: T3 controls 0, next T0.
